// File: rtl/cv_z80_bus_master.sv
// Z80-style bus cycle master: sequences mem/io read/write and refresh cycles,
// advancing one T-state per clk_en_i pulse, with registered active-low strobes.
module cv_z80_bus_master #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [7:0]  rdata_o,
    output logic [15:0] a_o,
    output logic [7:0]  d_o,
    output logic        d_oe_o,
    output logic        mreq_n_o,
    output logic        iorq_n_o,
    output logic        rd_n_o,
    output logic        wr_n_o,
    output logic        rfsh_n_o,
    input  logic        wait_n_i,
    input  logic [7:0]  d_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_R1, S_R2
    } state_t;

    localparam logic [2:0] OP_RFSH  = 3'b100;
    localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;     // bit1 = io, bit0 = write
    logic [7:0] wait_cnt_q;
    logic       to_q;
    logic       req_ok, accept, done_d, cap_rd, do_wait, wait_inc, to_set;
    logic       mreq_d, iorq_d, rd_d, wr_d, rfsh_d, oe_d;

    assign req_ok = req_i && (op_i <= OP_RFSH);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        done_d   = 1'b0;
        cap_rd   = 1'b0;
        do_wait  = 1'b0;
        wait_inc = 1'b0;
        to_set   = 1'b0;
        case (state_q)
            S_IDLE: accept = req_ok;
            S_T1:   if (clk_en_i) state_d = S_T2;
            S_T2: begin
                if (clk_en_i) begin
                    if (op_q[1]) state_d = S_TWA;
                    else         do_wait = 1'b1;
                end
            end
            S_TWA, S_TW: do_wait = clk_en_i;
            S_T3: begin
                if (clk_en_i) begin
                    done_d  = 1'b1;
                    cap_rd  = !op_q[0];
                    state_d = S_IDLE;
                    accept  = req_ok;
                end
            end
            S_R1: if (clk_en_i) state_d = S_R2;
            S_R2: begin
                if (clk_en_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    accept  = req_ok;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter reaching the limit forces T3; a limit of 0 therefore skips TW entirely.
        if (do_wait) begin
            if (wait_cnt_q == WAIT_MAX) begin
                state_d = S_T3;
                to_set  = !wait_n_i;
            end else if (!wait_n_i) begin
                state_d  = S_TW;
                wait_inc = 1'b1;
            end else begin
                state_d = S_T3;
            end
        end

        if (accept) state_d = (op_i == OP_RFSH) ? S_R1 : S_T1;
    end

    assign op_d = accept ? op_i[1:0] : op_q;

    // Strobes are decoded from the next state so they leave the register cleanly.
    always_comb begin
        mreq_d = 1'b1;
        iorq_d = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        rfsh_d = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            S_T1: begin
                mreq_d = op_d[1];
                rd_d   = op_d[1] | op_d[0];
                oe_d   = op_d[0];
            end
            S_T2, S_TWA, S_TW, S_T3: begin
                mreq_d = op_d[1];
                iorq_d = !op_d[1];
                rd_d   = op_d[0];
                wr_d   = !op_d[0];
                oe_d   = op_d[0];
            end
            S_R1: rfsh_d = 1'b0;
            S_R2: begin
                rfsh_d = 1'b0;
                mreq_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            wait_cnt_q <= 8'd0;
            to_q       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            rdata_o    <= 8'd0;
            a_o        <= 16'd0;
            d_o        <= 8'd0;
            d_oe_o     <= 1'b0;
            mreq_n_o   <= 1'b1;
            iorq_n_o   <= 1'b1;
            rd_n_o     <= 1'b1;
            wr_n_o     <= 1'b1;
            rfsh_n_o   <= 1'b1;
        end else begin
            state_q   <= state_d;
            busy_o    <= (state_d != S_IDLE);
            done_o    <= done_d;
            timeout_o <= done_d & to_q;
            d_oe_o    <= oe_d;
            mreq_n_o  <= mreq_d;
            iorq_n_o  <= iorq_d;
            rd_n_o    <= rd_d;
            wr_n_o    <= wr_d;
            rfsh_n_o  <= rfsh_d;
            if (cap_rd) rdata_o <= d_i;
            if (accept) begin
                op_q       <= op_i[1:0];
                a_o        <= addr_i;
                d_o        <= wdata_i;
                wait_cnt_q <= 8'd0;
                to_q       <= 1'b0;
            end else begin
                if (wait_inc) wait_cnt_q <= wait_cnt_q + 8'd1;
                if (to_set)   to_q       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cv_z80_bus_master.sv
// Directed bench for cv_z80_bus_master: counts strobe-low T-states per cycle
// and compares against hand-computed bus timings.
module tb_cv_z80_bus_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        wait_n = 1'b1;
    logic [7:0]  d_bus = 8'h00;
    logic        busy_o, done_o, timeout_o, d_oe_o;
    logic [7:0]  rdata_o, d_o;
    logic [15:0] a_o;
    logic        mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_ovl = 0;
    int cnt[6];   // T-states low: 0 mreq, 1 iorq, 2 rd, 3 wr, 4 rfsh, 5 d_oe high
    bit ok;
    int done_before;

    cv_z80_bus_master #(.WAIT_LIMIT(4)) dut (
        .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .req_i(req),
        .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .rdata_o(rdata_o), .a_o(a_o), .d_o(d_o), .d_oe_o(d_oe_o),
        .mreq_n_o(mreq_n_o), .iorq_n_o(iorq_n_o), .rd_n_o(rd_n_o),
        .wr_n_o(wr_n_o), .rfsh_n_o(rfsh_n_o), .wait_n_i(wait_n), .d_i(d_bus)
    );

    always #5 clk = ~clk;
    // One T-state per two clocks, changed well clear of both edges.
    always @(posedge clk) begin
        #2 clk_en = ~clk_en;
    end

    // Each negedge with clk_en high is the last sample of a T-state.
    always @(negedge clk) begin
        if (done_o) n_done++;
        if (!mreq_n_o && !iorq_n_o) n_ovl++;
        if (clk_en && !reset) begin
            if (!mreq_n_o) cnt[0]++;
            if (!iorq_n_o) cnt[1]++;
            if (!rd_n_o)   cnt[2]++;
            if (!wr_n_o)   cnt[3]++;
            if (!rfsh_n_o) cnt[4]++;
            if (d_oe_o)    cnt[5]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        for (int i = 0; i < 6; i++) cnt[i] = 0;
    endtask

    // Presents a request for one clk; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [7:0] w);
        @(posedge clk);
        #1;
        clr_mon();
        req = 1'b1; op = o; addr = a; wdata = w;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_en_edges(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (clk_en) break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_strobes", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o}, 5'b11111);
        check("rst_oe", d_oe_o, 0);
        check("rst_bus", {a_o, d_o, rdata_o}, 32'h0);
        reset = 1'b0;

        // Reserved op is ignored
        done_before = n_done;
        issue(3'b101, 16'hABCD, 8'h11);
        check("rsv_busy", busy_o, 0);
        check("rsv_addr", a_o, 16'h0000);
        repeat (6) @(posedge clk);
        check("rsv_done", n_done, done_before);

        // Mem read, no wait
        wait_n = 1'b1; d_bus = 8'h5A;
        issue(3'b000, 16'h8000, 8'h00);
        check("mrd_busy", busy_o, 1);
        check("mrd_t1", {mreq_n_o, rd_n_o, a_o}, {2'b00, 16'h8000});
        wait_done(ok);
        check("mrd_done", ok, 1);
        check("mrd_mreq", cnt[0], 3);
        check("mrd_rd", cnt[2], 3);
        check("mrd_iorq_wr", cnt[1] + cnt[3], 0);
        check("mrd_rdata", rdata_o, 8'h5A);
        check("mrd_to", timeout_o, 0);
        check("mrd_idle_strobes", {busy_o, mreq_n_o, rd_n_o}, 3'b011);
        @(negedge clk);
        check("mrd_done_pulse", done_o, 0);
        check("mrd_addr_hold", a_o, 16'h8000);

        // IO write, one automatic wait
        issue(3'b011, 16'h007F, 8'h0F);
        wait_done(ok);
        check("iow_done", ok, 1);
        check("iow_iorq", cnt[1], 3);
        check("iow_wr", cnt[3], 3);
        check("iow_oe", cnt[5], 4);
        check("iow_mreq_rd", cnt[0] + cnt[2], 0);
        check("iow_bus", {a_o, d_o}, {16'h007F, 8'h0F});
        check("iow_oe_off", d_oe_o, 0);

        // Mem write with exactly three wait states
        wait_n = 1'b0;
        issue(3'b001, 16'h6000, 8'hC7);
        wait_en_edges(4);
        wait_n = 1'b1;
        wait_done(ok);
        check("mwr_done", ok, 1);
        check("mwr_wr", cnt[3], 5);
        check("mwr_mreq", cnt[0], 6);
        check("mwr_oe", cnt[5], 6);
        check("mwr_rd", cnt[2], 0);
        check("mwr_to", timeout_o, 0);
        check("mwr_d", d_o, 8'hC7);

        // Wait limit of 4 forces T3 and flags a timeout
        wait_n = 1'b0; d_bus = 8'hC3;
        issue(3'b000, 16'h1111, 8'h00);
        wait_done(ok);
        check("to_done", ok, 1);
        check("to_rd", cnt[2], 7);
        check("to_mreq", cnt[0], 7);
        check("to_flag", timeout_o, 1);
        check("to_rdata", rdata_o, 8'hC3);
        wait_n = 1'b1;
        @(negedge clk);
        check("to_pulse", {done_o, timeout_o}, 2'b00);

        // Refresh followed by a back-to-back mem read
        wait_n = 1'b0; d_bus = 8'hA5;
        @(posedge clk);
        #1;
        clr_mon();
        req = 1'b1; op = 3'b100; addr = 16'h1234;
        @(posedge clk);
        #1;
        check("rf_r1", {rfsh_n_o, mreq_n_o, a_o}, {2'b01, 16'h1234});
        op = 3'b000; addr = 16'h8001;
        wait_done(ok);
        req = 1'b0;
        check("rf_done", ok, 1);
        check("rf_rfsh", cnt[4], 2);
        check("rf_mreq", cnt[0], 1);
        check("rf_rdwr", cnt[2] + cnt[3], 0);
        check("b2b_t1", {busy_o, mreq_n_o, rd_n_o, rfsh_n_o, a_o}, {4'b1001, 16'h8001});
        clr_mon();
        wait_n = 1'b1;
        wait_done(ok);
        check("b2b_done", ok, 1);
        check("b2b_mreq", cnt[0], 3);
        check("b2b_rdata", rdata_o, 8'hA5);

        // Reset in TW of an io read aborts without done
        wait_n = 1'b0;
        issue(3'b010, 16'h0055, 8'h00);
        wait_en_edges(3);
        check("rtw_strobes", {iorq_n_o, rd_n_o}, 2'b00);
        done_before = n_done;
        #1;
        reset = 1'b1;
        #1;
        check("rtw_async", {iorq_n_o, rd_n_o, busy_o}, 3'b110);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_n = 1'b1;
        repeat (4) @(posedge clk);
        check("rtw_no_done", n_done, done_before);
        check("rtw_rdata", rdata_o, 8'h00);
        d_bus = 8'h3C;
        issue(3'b000, 16'h4321, 8'h00);
        wait_done(ok);
        check("post_rst_done", ok, 1);
        check("post_rst_mreq", cnt[0], 3);
        check("post_rst_rdata", rdata_o, 8'h3C);

        check("no_overlap", n_ovl, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
